mod_sqrt_unit: RTL and testbench



---
 rtl/mod_sqrt_unit.sv | 136 +++++++++++++
 tb/tb_mod_sqrt_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_sqrt_unit.sv
// Iterative restoring square root: floor(sqrt(r_in)) one root bit per cycle, MSB first.
// approx_bits skips the low result iterations; rem is always exact against the final mag.
module mod_sqrt_unit #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   r_in,
    input  logic [3:0]        approx_bits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  mag,
    output logic [IN_W-1:0]   rem
);

    localparam int PW = OUT_W + 1;
    localparam int TW = OUT_W + 3;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    op_q, op_d;
    logic [3:0]         n_q, n_d;
    logic [3:0]         idx_q, idx_d;
    logic [OUT_W-1:0]   root_q, root_d;
    logic [PW-1:0]      prem_q, prem_d;
    logic [OUT_W-1:0]   mag_q, mag_d;
    logic [IN_W-1:0]    rem_q, rem_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic [1:0]         op_bits;
    logic [TW-1:0]      trial_base;
    logic [TW-1:0]      trial_sub;
    logic [TW-1:0]      trial_diff;
    logic               take;
    logic [OUT_W-1:0]   root_iter;
    logic [PW-1:0]      prem_iter;
    logic [OUT_W-1:0]   mag_iter;
    logic [IN_W-1:0]    mag_sq;

    // One restoring step; the partial remainder never exceeds 2*root, so PW bits suffice.
    always_comb begin
        op_bits    = op_q[2*idx_q +: 2];
        trial_base = TW'({prem_q, op_bits});
        trial_sub  = TW'({root_q, 2'b01});
        trial_diff = trial_base - trial_sub;
        take       = (trial_base >= trial_sub);
        root_iter  = OUT_W'({root_q, take});
        prem_iter  = take ? PW'(trial_diff) : PW'(trial_base);
        mag_iter   = root_iter << n_q;
        mag_sq     = IN_W'(mag_iter) * IN_W'(mag_iter);
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        n_d         = n_q;
        idx_d       = idx_q;
        root_d      = root_q;
        prem_d      = prem_q;
        mag_d       = mag_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d    = r_in;
                    n_d     = approx_bits;
                    idx_d   = 4'(OUT_W - 1);
                    root_d  = '0;
                    prem_d  = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                root_d = root_iter;
                prem_d = prem_iter;
                // The last iteration lands on bit n; rem is recomputed exactly from the final mag.
                if (idx_q == n_q) begin
                    mag_d       = mag_iter;
                    rem_d       = op_q - mag_sq;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            root_q      <= '0;
            prem_q      <= '0;
            mag_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            root_q      <= root_d;
            prem_q      <= prem_d;
            mag_q       <= mag_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign mag       = mag_q;
    assign rem       = rem_q;

endmodule

// File: tb/tb_mod_sqrt_unit.sv
// Self-checking bench for mod_sqrt_unit: vector table, random operands against a
// greedy reference model, backpressure and mid-operation reset sequences.
module tb_mod_sqrt_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] r_in;
    logic [3:0]  approx_bits;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] mag;
    logic [31:0] rem;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  n;
        logic [15:0] mag;
        logic [31:0] rem;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] mag;
        logic [31:0] rem;
        int          lat;
    } exp_t;

    exp_t sb[$];

    mod_sqrt_unit #(.IN_W(32), .OUT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .r_in        (r_in),
        .approx_bits (approx_bits),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .mag         (mag),
        .rem         (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Largest multiple of 2^n whose square fits under r, built greedily bit by bit.
    function automatic exp_t model(input logic [31:0] r, input logic [3:0] n);
        exp_t        e;
        logic [15:0] m;
        logic [15:0] c;
        m = '0;
        for (int b = 15; b >= int'(n); b--) begin
            c = m | (16'h1 << b);
            if (64'(c) * 64'(c) <= 64'(r)) m = c;
        end
        e.mag = m;
        e.rem = r - 32'(m) * 32'(m);
        e.lat = 16 - int'(n);
        return e;
    endfunction

    task automatic applyStimulus(input logic [31:0] r, input logic [3:0] n, input exp_t e);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            checkValue("in_ready_wait", 32'(in_ready), 32'd1);
            return;
        end
        in_valid    = 1'b1;
        r_in        = r;
        approx_bits = n;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        int   lat;
        exp_t e;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkValue("out_valid_seen", 32'(out_valid), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkValue("mag", 32'(mag), 32'(e.mag));
            checkValue("rem", rem, e.rem);
            checkValue("latency", 32'(lat), 32'(e.lat));
        end
    endtask

    task automatic handshake();
        @(posedge clk); #1;
        checkValue("in_ready_after_hs", 32'(in_ready), 32'd1);
        checkValue("out_valid_cleared", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t tbl[10];
        exp_t e;
        logic [31:0] rr;
        logic [3:0]  nn;
        int          saw_valid;

        tbl[0] = '{32'd0,          4'd0,  16'd0,      32'd0,          16};
        tbl[1] = '{32'd25,         4'd0,  16'd5,      32'd0,          16};
        tbl[2] = '{32'hFFFF_FFFF,  4'd0,  16'hFFFF,   32'h1FFFE,      16};
        tbl[3] = '{32'd1000000,    4'd0,  16'd1000,   32'd0,          16};
        tbl[4] = '{32'd1000000,    4'd4,  16'd992,    32'd15936,      12};
        tbl[5] = '{32'h4000_0000,  4'd15, 16'h8000,   32'd0,          1};
        tbl[6] = '{32'd144,        4'd0,  16'd12,     32'd0,          16};
        tbl[7] = '{32'hFFFF_FFFF,  4'd15, 16'h8000,   32'hBFFF_FFFF,  1};
        tbl[8] = '{32'd99,         4'd8,  16'd0,      32'd99,         8};
        tbl[9] = '{32'd2,          4'd0,  16'd1,      32'd1,          16};

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        r_in        = '0;
        approx_bits = '0;

        repeat (3) @(posedge clk);
        #1;
        checkValue("reset_in_ready", 32'(in_ready), 32'd0);
        checkValue("reset_out_valid", 32'(out_valid), 32'd0);
        checkValue("reset_mag", 32'(mag), 32'd0);
        checkValue("reset_rem", rem, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkValue("in_ready_after_reset", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            e.mag = tbl[i].mag;
            e.rem = tbl[i].rem;
            e.lat = tbl[i].lat;
            applyStimulus(tbl[i].r, tbl[i].n, e);
            checkOutput();
            handshake();
        end

        for (int i = 0; i < 6; i++) begin
            rr = $urandom;
            nn = 4'($urandom_range(0, 15));
            applyStimulus(rr, nn, model(rr, nn));
            checkOutput();
            handshake();
        end

        // Backpressure: result must hold and a new operand must be refused.
        out_ready = 1'b0;
        e.mag = 16'd5; e.rem = 32'd0; e.lat = 16;
        applyStimulus(32'd25, 4'd0, e);
        checkOutput();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            r_in     = 32'd144;
            @(posedge clk); #1;
            checkValue("bp_mag", 32'(mag), 32'd5);
            checkValue("bp_rem", rem, 32'd0);
            checkValue("bp_in_ready", 32'(in_ready), 32'd0);
            checkValue("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        handshake();
        repeat (20) @(posedge clk);
        #1;
        checkValue("bp_no_queued_result", 32'(out_valid), 32'd0);

        // Reset in the middle of an iteration sequence.
        e.mag = 16'd1000; e.rem = 32'd0; e.lat = 16;
        applyStimulus(32'd1000000, 4'd0, e);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkValue("midrst_out_valid", 32'(out_valid), 32'd0);
        checkValue("midrst_mag", 32'(mag), 32'd0);
        checkValue("midrst_rem", rem, 32'd0);
        checkValue("midrst_in_ready", 32'(in_ready), 32'd0);
        #3;
        rst = 1'b0;
        sb.delete();
        saw_valid = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1;
        end
        checkValue("midrst_no_spurious_valid", 32'(saw_valid), 32'd0);
        checkValue("midrst_in_ready_after", 32'(in_ready), 32'd1);
        e.mag = 16'd12; e.rem = 32'd0; e.lat = 16;
        applyStimulus(32'd144, 4'd0, e);
        checkOutput();
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
